// File: rtl/ram_loader_pkg.sv
// Shared types, constants and checksum helper for ram_loader.
// The VERIFY state exists only when RAM_LOADER_VERIFY_EN is defined.
package ram_loader_pkg;
  localparam int DATA_W        = 16;
  localparam int DEFAULT_DEPTH = 64;

`ifdef RAM_LOADER_VERIFY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  function automatic logic [DATA_W-1:0] csum_step(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction
endpackage

// File: rtl/ram_loader_if.sv
// Source stream and RAM write/read bus of ram_loader.
// master = the loader, slave = source plus RAM.
interface ram_loader_if #(parameter int ADDR_W = 6);
  import ram_loader_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  in_valid, in_data, mem_data_out,
    output in_ready, mem_load, mem_address, mem_data_in
  );

  modport slave (
    output in_valid, in_data, mem_data_out,
    input  in_ready, mem_load, mem_address, mem_data_in
  );
endinterface

// File: rtl/ram_loader_addr_counter.sv
// Up-counter with clear and enable. It flags the terminal count at DEPTH-1 and
// wraps to 0 there, so the address never passes the last word.
module addr_counter #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  assign tc = (addr == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       addr <= '0;
    else if (clr)  addr <= '0;
    else if (en)   addr <= tc ? '0 : addr + 1'b1;
  end
endmodule

// File: rtl/ram_loader.sv
// Streams DEPTH words from a valid/ready source into a RAM.
// Defining RAM_LOADER_VERIFY_EN adds an XOR-checksum read-back pass with error/err_addr.
//
//   state    | meaning
//   S_IDLE   | waiting for start (after reset or abort)
//   S_LOAD   | accepting words, one write per handshake
//   S_VERIFY | reading back 0..DEPTH-1 and checksumming (macro only)
//   S_DONE   | last transfer complete, done held until start
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
`ifdef RAM_LOADER_VERIFY_EN
  ,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
`endif
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              tc;
  logic              cnt_clr;
  logic              cnt_en;
  logic              hs;

  addr_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .addr (addr),
    .tc   (tc)
  );

  assign hs               = (state == S_LOAD) && bus.in_valid;
  assign bus.mem_address  = addr;
  assign bus.mem_data_in  = bus.in_data;
`ifdef RAM_LOADER_VERIFY_EN
  assign busy = (state == S_LOAD) || (state == S_VERIFY);
`else
  assign busy = (state == S_LOAD);
`endif
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Strobes depend on state, so an async reset drops mem_load immediately.
  always_comb begin
    state_nxt    = state;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    bus.in_ready = 1'b0;
    bus.mem_load = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_LOAD;
          cnt_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.mem_load = bus.in_valid;
        cnt_en       = bus.in_valid;
        if (abort)
          state_nxt = S_IDLE;
        else if (bus.in_valid && tc)
`ifdef RAM_LOADER_VERIFY_EN
          state_nxt = S_VERIFY;
`else
          state_nxt = S_DONE;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_VERIFY: begin
        cnt_en = 1'b1;
        if (abort)   state_nxt = S_IDLE;
        else if (tc) state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          count <= '0;
    else if (cnt_clr) count <= '0;
    else if (hs)      count <= count + 1'b1;
  end

`ifdef RAM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] load_sum;
  logic [DATA_W-1:0] verify_sum;
  logic [DATA_W-1:0] verify_sum_nxt;

  assign verify_sum_nxt = csum_step(verify_sum, bus.mem_data_out);

  // The final read-back word is folded in combinationally for the end-of-pass compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sum   <= '0;
      verify_sum <= '0;
      error      <= 1'b0;
      err_addr   <= '0;
    end else if (cnt_clr) begin
      load_sum   <= '0;
      verify_sum <= '0;
      error      <= 1'b0;
      err_addr   <= '0;
    end else begin
      if (hs)
        load_sum <= csum_step(load_sum, bus.in_data);
      if (state == S_VERIFY) begin
        verify_sum <= verify_sum_nxt;
        if (tc && !abort && (verify_sum_nxt != load_sum)) begin
          error    <= 1'b1;
          err_addr <= addr;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed sequence with random data and stalls.
// Build with RAM_LOADER_VERIFY_EN to also exercise the read-back pass.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
`ifdef RAM_LOADER_VERIFY_EN
  logic              error;
  logic [ADDR_W-1:0] err_addr;
`endif

  ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  ram_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .count (count)
`ifdef RAM_LOADER_VERIFY_EN
    ,
    .error    (error),
    .err_addr (err_addr)
`endif
  );

  always #5 clk = ~clk;

  // RAM model with an optional stuck corruption of word 5 on read.
  logic [15:0] ram [DEPTH];
  logic        corrupt = 1'b0;
  int          n_writes = 0;

  always @(posedge clk) begin
    if (bus.mem_load) begin
      ram[bus.mem_address] <= bus.mem_data_in;
      n_writes++;
    end
  end

  assign bus.mem_data_out = (corrupt && bus.mem_address == 6'd5) ?
                            (ram[bus.mem_address] ^ 16'h00FF) : ram[bus.mem_address];

  // Reference: the k-th accepted word of a transfer belongs at address k.
  logic [15:0] exp_ram [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer();
    @(negedge clk);
    start = 1'b1; abort = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_busy",  busy, 1);
    chk("start_done",  done, 0);
    chk("start_count", count, 0);
    chk("start_addr",  bus.mem_address, 0);
  endtask

  // Sends n words; stall_pct percent of cycles have in_valid low.
  task automatic load_words(input int n, input int stall_pct, input bit seq, input bit noise);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(99) >= stall_pct);
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      bus.in_data = seq ? 16'(16'h1000 + k) : 16'($urandom);
      #1;
      chk("load_ready", bus.in_ready, 1);
      chk("load_addr",  bus.mem_address, k);
      chk("load_strobe", bus.mem_load, bus.in_valid);
      if (bus.in_valid) begin
        chk("load_wdata", bus.mem_data_in, bus.in_data);
        exp_ram[k] = bus.in_data;
        k++;
      end
    end
  endtask

  task automatic check_ram(input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("ram[%0d]", i), ram[i], exp_ram[i]);
  endtask

  task automatic finish_xfer(input int w0, input bit exp_err);
    @(negedge clk);
    bus.in_valid = 1'b0; start = 1'b0;
    #1;
`ifdef RAM_LOADER_VERIFY_EN
    for (int c = 0; c < DEPTH; c++) begin
      chk("verify_busy", busy, 1);
      chk("verify_addr", bus.mem_address, c);
      chk("verify_noload", bus.mem_load, 0);
      @(negedge clk);
      #1;
    end
    chk("verify_error", error, exp_err);
    chk("verify_err_addr", err_addr, exp_err ? DEPTH - 1 : 0);
`endif
    chk("end_done",   done, 1);
    chk("end_busy",   busy, 0);
    chk("end_count",  count, DEPTH);
    chk("end_ready",  bus.in_ready, 0);
    chk("end_writes", n_writes - w0, DEPTH);
    check_ram(DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [15:0] keep30;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h0;
    #2;
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_load",  bus.mem_load, 0);
    @(negedge clk);
    rst = 1'b0;
    w0 = n_writes;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("idle_ready", bus.in_ready, 0);
      chk("idle_load",  bus.mem_load, 0);
      chk("idle_busy",  busy, 0);
    end
    chk("idle_writes", n_writes - w0, 0);

    // Back-to-back sequential words.
    start_xfer();
    w0 = n_writes;
    load_words(DEPTH, 0, 1'b1, 1'b0);
    finish_xfer(w0, 1'b0);

    // Random data, random stalls, start noise while busy.
    start_xfer();
    w0 = n_writes;
    load_words(DEPTH, 50, 1'b0, 1'b1);
    finish_xfer(w0, 1'b0);

`ifdef RAM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    start_xfer();
    chk("start_clears_err", error, 0);
    w0 = n_writes;
    load_words(DEPTH, 25, 1'b0, 1'b0);
    finish_xfer(w0, 1'b1);
    corrupt = 1'b0;
    start_xfer();
    chk("restart_clears_err", error, 0);
    chk("restart_clears_err_addr", err_addr, 0);
    w0 = n_writes;
    load_words(DEPTH, 10, 1'b0, 1'b0);
    finish_xfer(w0, 1'b0);
`endif

    // Abort after 10 words, then idle traffic must be ignored.
    start_xfer();
    w0 = n_writes;
    load_words(10, 20, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0; abort = 1'b1;
    #1;
    chk("abort_cycle_load", bus.mem_load, 0);
    @(negedge clk);
    abort = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("abort_busy",  busy, 0);
    chk("abort_done",  done, 0);
    chk("abort_count", count, 10);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_idle_ready", bus.in_ready, 0);
      chk("abort_idle_load",  bus.mem_load, 0);
    end
    chk("abort_writes", n_writes - w0, 10);
    check_ram(10);

    // Restart at address 0; abort coincides with the final handshake.
    start_xfer();
    w0 = n_writes;
    load_words(DEPTH - 1, 30, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'($urandom); abort = 1'b1;
    #1;
    chk("final_abort_load", bus.mem_load, 1);
    chk("final_abort_addr", bus.mem_address, DEPTH - 1);
    exp_ram[DEPTH-1] = bus.in_data;
    @(negedge clk);
    abort = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("final_abort_busy",   busy, 0);
    chk("final_abort_done",   done, 0);
    chk("final_abort_count",  count, DEPTH);
    chk("final_abort_writes", n_writes - w0, DEPTH);
    check_ram(DEPTH);

    // Reset in the middle of a write cycle at address 30.
    keep30 = ram[30];
    start_xfer();
    load_words(30, 0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = ~keep30;
    #1;
    chk("pre_rst_load", bus.mem_load, 1);
    chk("pre_rst_addr", bus.mem_address, 30);
    #1;
    rst = 1'b1;
    w0 = n_writes;
    #1;
    chk("mid_rst_load",  bus.mem_load, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_done",  done, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_addr",  bus.mem_address, 0);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_writes", n_writes - w0, 0);
    chk("mid_rst_ram30",  ram[30], keep30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 64: number of words loaded per transfer.
REQ-002 The block SHALL expose parameter ADDR_W, default 6: memory address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: begin a transfer when sampled high in IDLE or DONE.
REQ-006 The block SHALL have port abort, input, 1: cancel the transfer in progress.
REQ-007 The block SHALL have port in_valid, input, 1: the source presents a word.
REQ-008 The block SHALL have port in_data, input, 16: the word to be written.
REQ-009 The block SHALL have port in_ready, output, 1: the loader accepts a word this cycle.
REQ-010 The block SHALL have port mem_load, output, 1: write strobe to the downstream 64-word RAM.
REQ-011 The block SHALL have port mem_address, output, ADDR_W: RAM address.
REQ-012 The block SHALL have port mem_data_in, output, 16: RAM write data.
REQ-013 The block SHALL have port mem_data_out, input, 16: combinational RAM read data.
REQ-014 The block SHALL have port busy, output, 1: a transfer or verify pass is in progress.
REQ-015 The block SHALL have port done, output, 1: the last transfer completed.
REQ-016 The block SHALL have port count, output, ADDR_W+1: number of words written in the current or last transfer.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, VERIFY (present only under the macro) and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL move to LOAD on the next edge, clearing the address counter, count and done.
REQ-019 In LOAD: in_ready=1; mem_address=addr; mem_data_in=in_data; mem_load=in_valid; all combinational.
REQ-020 A handshake (in_valid and in_ready both high) SHALL write in_data to addr at that edge, then increment addr and count.
REQ-021 in_valid low in LOAD SHALL hold addr and keep mem_load low; stalls of any length SHALL be legal.
REQ-022 The handshake at addr=DEPTH-1 SHALL go to DONE (or VERIFY under the macro), with count=DEPTH.
REQ-023 Outside LOAD: in_ready=0, mem_load=0, and in_valid SHALL be ignored.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in LOAD or VERIFY SHALL return to IDLE on the next edge with done=0 and count held; an abort coinciding with the final handshake SHALL still commit that write, and abort SHALL take priority for the next state.
REQ-026 busy SHALL be 1 exactly in LOAD and VERIFY.
REQ-027 done SHALL be 1 exactly in DONE and SHALL be held until start or reset.
REQ-028 The address counter SHALL never exceed DEPTH-1, and no write SHALL occur past DEPTH-1.

Reset
REQ-029 rst SHALL force, asynchronously, state=IDLE, addr=0, count=0, done=0, busy=0, in_ready=0 and mem_load=0.
REQ-030 rst during LOAD SHALL immediately deassert mem_load, so no partial write occurs after the reset assertion.

Configuration
REQ-031 With RAM_LOADER_VERIFY_EN defined, the block SHALL buffer nothing and add outputs error (1 bit) and err_addr (ADDR_W bits).
REQ-032 With the macro, VERIFY SHALL step addr from 0 to DEPTH-1, one address per cycle, with mem_load=0, and compare mem_data_out against a running 16-bit XOR checksum.
REQ-033 With the macro, a checksum recomputed in VERIFY that differs from the LOAD checksum at the end of the pass SHALL set error=1, with err_addr=DEPTH-1.
REQ-034 With the macro, error and err_addr SHALL clear on start or rst.
REQ-035 Without the macro, LOAD SHALL go directly to DONE, and the error, err_addr and checksum logic SHALL be absent.

Structure
REQ-036 Package ram_loader_pkg SHALL hold the state enum and the constants DATA_W=16 and DEFAULT_DEPTH=64.
REQ-037 One sub-module, addr_counter, SHALL provide the clear, enable and terminal-count up-counter, instantiated once.

Verification
REQ-038 Reset, then start, then 64 words 0x1000+i on consecutive cycles -> mem_load for 64 cycles at addresses 0..63; done=1 and count=64 one cycle after the last word.
REQ-039 in_valid toggling 1/0 while 64 words load -> exactly 64 writes, addr advancing only on handshakes, and the RAM contents match.
REQ-040 abort after word 10 -> IDLE next cycle; done=0; count=10; no further mem_load; a new start then restarts at address 0.
REQ-041 rst asserted mid-LOAD at address 30 -> mem_load=0 immediately and all outputs at reset values before the next edge.
REQ-042 start pulsed during LOAD and in_valid driven in IDLE -> no effect on the state, writes or in_ready.
REQ-043 With RAM_LOADER_VERIFY_EN and the RAM model corrupting word 5 -> error=1 after the VERIFY pass and err_addr=63; with a clean RAM -> error=0 and done=1 after 64 VERIFY cycles.
